// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - stall/flush controller for the 5-stage pipeline; HAZARD_STATS_EN adds hazard counters
module hazard_unit #(
    parameter int STAT_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              exmem_dREN,
    input  logic              exmem_dWEN,
    input  logic              idex_MemRead,
    input  logic [4:0]        idex_wsel,
    input  logic [4:0]        ifid_rs,
    input  logic [4:0]        ifid_rt,
    input  logic              ifid_uses_rt,
    input  logic              redirect,
    input  logic              halt,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              halted,
`ifdef HAZARD_STATS_EN
    output logic [STAT_W-1:0] stall_cycles,
    output logic [STAT_W-1:0] lu_count,
    output logic [STAT_W-1:0] flush_count,
`endif
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        LUSTALL = 2'd2,
        HALTED  = 2'd3
    } state_t;

    state_t state, state_next;

    logic memstall;
    logic lu;
    logic redirect_taken;

    assign memstall = (exmem_dREN | exmem_dWEN) & ~dhit;

    // A $zero destination never creates a real dependence.
    assign lu = idex_MemRead && (idex_wsel != 5'd0) &&
                ((idex_wsel == ifid_rs) || (ifid_uses_rt && (idex_wsel == ifid_rt)));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    assign state_o = state;

    always_comb begin
        pc_en          = 1'b1;
        ifid_en        = 1'b1;
        idex_en        = 1'b1;
        exmem_en       = 1'b1;
        memwb_en       = 1'b1;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        exmem_flush    = 1'b0;
        halted         = 1'b0;
        redirect_taken = 1'b0;
        state_next     = state;

        if (RST) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            state_next = RUN;
        end else if (state == HALTED) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            halted     = 1'b1;
            state_next = HALTED;
        end else if (memstall) begin
            // Whole pipe freezes; a pending fetch miss is irrelevant here.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            state_next = MEMWAIT;
        end else if (halt) begin
            // Let the halt retire into MEM/WB, then stop everything.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            state_next = HALTED;
        end else if (redirect) begin
            ifid_flush     = 1'b1;
            idex_flush     = 1'b1;
            exmem_flush    = 1'b1;
            redirect_taken = 1'b1;
            state_next     = RUN;
        end else if (lu && (state == RUN)) begin
            // LUSTALL ignores lu so each load inserts exactly one bubble.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            state_next = LUSTALL;
        end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
            state_next = RUN;
        end else begin
            state_next = RUN;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] stat_max;
    assign stat_max = {STAT_W{1'b1}};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cycles <= '0;
            lu_count     <= '0;
            flush_count  <= '0;
        end else if (state != HALTED) begin
            if (!pc_en && (stall_cycles != stat_max)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if ((state != LUSTALL) && (state_next == LUSTALL) && (lu_count != stat_max)) begin
                lu_count <= lu_count + 1'b1;
            end
            if (redirect_taken && (flush_count != stat_max)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end
`else
    logic [STAT_W-1:0] unused_stat_w;
    logic              unused_redirect_taken;
    assign unused_stat_w         = '0;
    assign unused_redirect_taken = redirect_taken;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed self-checking bench for hazard_unit
module tb_hazard_unit;

    logic       CLK;
    logic       RST;
    logic       ihit, dhit, exmem_dREN, exmem_dWEN, idex_MemRead;
    logic [4:0] idex_wsel, ifid_rs, ifid_rt;
    logic       ifid_uses_rt, redirect, halt;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, exmem_flush, halted;
    logic [1:0] state_o;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles, lu_count, flush_count;
`endif

    int checks;
    int failures;

    hazard_unit #(.STAT_W(32)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .ihit         (ihit),
        .dhit         (dhit),
        .exmem_dREN   (exmem_dREN),
        .exmem_dWEN   (exmem_dWEN),
        .idex_MemRead (idex_MemRead),
        .idex_wsel    (idex_wsel),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .ifid_uses_rt (ifid_uses_rt),
        .redirect     (redirect),
        .halt         (halt),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .exmem_en     (exmem_en),
        .memwb_en     (memwb_en),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .exmem_flush  (exmem_flush),
        .halted       (halted),
`ifdef HAZARD_STATS_EN
        .stall_cycles (stall_cycles),
        .lu_count     (lu_count),
        .flush_count  (flush_count),
`endif
        .state_o      (state_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Packed view: {pc,ifid,idex,exmem,memwb, fl_ifid,fl_idex,fl_exmem, halted, state[1:0]}
    logic [10:0] obs;
    assign obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                  ifid_flush, idex_flush, exmem_flush, halted, state_o};

    localparam logic [10:0] ZERO       = 11'b00000_000_0_00;
    localparam logic [10:0] ADV_RUN    = 11'b11111_000_0_00;
    localparam logic [10:0] ADV_LUS    = 11'b11111_000_0_10;
    localparam logic [10:0] ADV_MW     = 11'b11111_000_0_01;
    localparam logic [10:0] LU_STALL   = 11'b00111_010_0_00;
    localparam logic [10:0] FREEZE_RUN = 11'b00000_000_0_00;
    localparam logic [10:0] FREEZE_MW  = 11'b00000_000_0_01;
    localparam logic [10:0] FREEZE_LUS = 11'b00000_000_0_10;
    localparam logic [10:0] REDIR_RUN  = 11'b11111_111_0_00;
    localparam logic [10:0] REDIR_MW   = 11'b11111_111_0_01;
    localparam logic [10:0] IMISS_RUN  = 11'b01111_100_0_00;
    localparam logic [10:0] HALT_RUN   = 11'b00001_000_0_00;
    localparam logic [10:0] HALTED_V   = 11'b00000_000_1_11;

    task automatic check(input string tag, input logic [10:0] exp);
        #1;
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ihit = 1'b1; dhit = 1'b0; exmem_dREN = 1'b0; exmem_dWEN = 1'b0;
        idex_MemRead = 1'b0; idex_wsel = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        ifid_uses_rt = 1'b1; redirect = 1'b0; halt = 1'b0;
    endtask

    task automatic set_lu();
        idex_MemRead = 1'b1; idex_wsel = 5'd8; ifid_rs = 5'd8; ifid_rt = 5'd0; ifid_uses_rt = 1'b1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        idle_inputs();
        RST = 1'b1;
        #12;
        check("reset_outputs", ZERO);

        @(negedge CLK);
        RST = 1'b0;
        check("run_advance", ADV_RUN);

        // Load-use on rs: one bubble, then advance
        set_lu();
        check("lu_stall", LU_STALL);
        tick();
        check("lustall_ignores_lu", ADV_LUS);
        idle_inputs();
        tick();
        check("lu_back_to_run", ADV_RUN);

        // Suppression: rt match without rt use, then $zero destination
        idex_MemRead = 1'b1; idex_wsel = 5'd8; ifid_rt = 5'd8; ifid_rs = 5'd3; ifid_uses_rt = 1'b0;
        check("lu_rt_unused", ADV_RUN);
        ifid_uses_rt = 1'b1;
        check("lu_rt_used", LU_STALL);
        idex_wsel = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        check("lu_reg0", ADV_RUN);
        idle_inputs();

        // Fetch miss
        ihit = 1'b0;
        check("imiss", IMISS_RUN);
        ihit = 1'b1;

        // Memory wait: 3 freeze cycles, redirect only honoured on dhit
        exmem_dREN = 1'b1; dhit = 1'b0; ihit = 1'b0;
        check("memstall_c1", FREEZE_RUN);
        tick();
        redirect = 1'b1;
        check("memstall_c2_redirect", FREEZE_MW);
        tick();
        check("memstall_c3", FREEZE_MW);
        dhit = 1'b1;
        check("dhit_redirect", REDIR_MW);
        tick();
        idle_inputs();
        check("after_memwait", ADV_RUN);

        // Redirect beats load-use
        set_lu();
        redirect = 1'b1;
        check("redirect_over_lu", REDIR_RUN);
        tick();
        idle_inputs();
        check("no_lustall_after_redirect", ADV_RUN);

        // Store stall
        exmem_dWEN = 1'b1; dhit = 1'b0;
        check("store_stall", FREEZE_RUN);
        tick();
        dhit = 1'b1;
        check("store_dhit", ADV_MW);
        tick();
        idle_inputs();

        // Memstall while in LUSTALL
        set_lu();
        tick();
        exmem_dREN = 1'b1; dhit = 1'b0;
        check("lustall_memstall", FREEZE_LUS);
        tick();
        check("lustall_to_memwait", FREEZE_MW);
        idle_inputs();
        check("memwait_release", ADV_MW);
        tick();
        check("memwait_to_run", ADV_RUN);

        // Async reset during MEMWAIT
        exmem_dREN = 1'b1; dhit = 1'b0;
        tick();
        check("pre_reset_memwait", FREEZE_MW);
        RST = 1'b1;
        check("reset_mid_memwait", ZERO);
        @(negedge CLK);
        RST = 1'b0;
        idle_inputs();
        check("post_reset_run", ADV_RUN);

        // Memstall outranks halt
        halt = 1'b1; exmem_dREN = 1'b1; dhit = 1'b0;
        check("memstall_over_halt", FREEZE_RUN);
        exmem_dREN = 1'b0;
        check("halt_drain", HALT_RUN);
        tick();
        for (int i = 0; i < 12; i++) begin
            ihit = 1'($urandom); dhit = 1'($urandom); exmem_dREN = 1'($urandom);
            redirect = 1'($urandom); halt = 1'($urandom);
            set_lu();
            check($sformatf("halted_%0d", i), HALTED_V);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
